// File: rtl/exp_lut_scheduler.sv
// Shares one fixed-latency exponential LUT between NUM_REQ requesters: round-robin
// grant, registered LUT operand, tag pipeline, and per-requester response slots.
module exp_lut_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int LUT_LATENCY = 0,
    parameter int DATA_W      = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_value,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_lut_valid,
    output logic [DATA_W-1:0]         o_lut_value,
    input  logic [DATA_W-1:0]         i_lut_exp,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0] o_rsp_value,
    input  logic [NUM_REQ-1:0]        i_rsp_ready
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    logic [NUM_REQ-1:0]            eligible;
    logic [NUM_REQ-1:0]            grant_oh;
    logic                          grant_any;
    logic [IDW-1:0]                winner;
    logic [IDW-1:0]                rr_q, rr_d;
    logic                          lut_vld_q;
    logic [DATA_W-1:0]             lut_val_q;
    logic [LUT_LATENCY:0]          vld_pipe_q;
    logic [LUT_LATENCY:0][IDW-1:0] id_pipe_q;
    logic                          cap;
    logic [IDW-1:0]                cap_id;

    // Round-robin search starting at rr_q; first eligible index wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        winner    = '0;
        grant_oh  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                winner    = IDW'(idx);
            end
        end
        if (grant_any && i_rst_n) grant_oh[winner] = 1'b1;
    end

    assign rr_d        = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    assign o_req_ready = grant_oh;
    assign o_lut_valid = lut_vld_q;
    assign o_lut_value = lut_val_q;
    assign cap         = vld_pipe_q[LUT_LATENCY];
    assign cap_id      = id_pipe_q[LUT_LATENCY];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_q       <= '0;
            lut_vld_q  <= 1'b0;
            lut_val_q  <= '0;
            vld_pipe_q <= '0;
            id_pipe_q  <= '0;
        end else begin
            lut_vld_q     <= grant_any;
            vld_pipe_q[0] <= grant_any;
            id_pipe_q[0]  <= winner;
            if (grant_any) begin
                rr_q      <= rr_d;
                lut_val_q <= i_req_value[winner*DATA_W +: DATA_W];
            end
            for (int i = 1; i <= LUT_LATENCY; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                id_pipe_q[i]  <= id_pipe_q[i-1];
            end
        end
    end

    // One outstanding lookup per requester: a slot is only refilled after it is consumed.
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_lane
        state_e            state_q;
        logic              rsp_vld_q;
        logic [DATA_W-1:0] rsp_val_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state_q   <= IDLE;
                rsp_vld_q <= 1'b0;
                rsp_val_q <= '0;
            end else begin
                case (state_q)
                    IDLE: if (grant_oh[r]) state_q <= BUSY;
                    BUSY: if (cap && cap_id == IDW'(r)) begin
                        state_q   <= DONE;
                        rsp_vld_q <= 1'b1;
                        rsp_val_q <= i_lut_exp;
                    end
                    DONE: if (i_rsp_ready[r]) begin
                        state_q   <= IDLE;
                        rsp_vld_q <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign eligible[r]                       = i_req_valid[r] && (state_q == IDLE);
        assign o_rsp_valid[r]                    = rsp_vld_q;
        assign o_rsp_value[r*DATA_W +: DATA_W]   = rsp_val_q;
    end

endmodule
